// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, opcode helpers and the 1149.1 transition graph.
// Imported by the pin synchroniser and the TAP top.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PAU_DR = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PAU_IR = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_e;

    function automatic logic [31:0] bypass_op(int unsigned len);
        logic [31:0] ones;
        ones = '1;
        return ones >> (32 - len);
    endfunction

    function automatic logic [31:0] idcode_op(int unsigned len);
        return bypass_op(len) & ~32'd1;
    endfunction

    function automatic tap_state_e tap_next(tap_state_e s, logic tms);
        tap_state_e n;
        unique case (s)
            TLR:    n = tms ? TLR    : RTI;
            RTI:    n = tms ? SEL_DR : RTI;
            SEL_DR: n = tms ? SEL_IR : CAP_DR;
            CAP_DR: n = tms ? EX1_DR : SH_DR;
            SH_DR:  n = tms ? EX1_DR : SH_DR;
            EX1_DR: n = tms ? UPD_DR : PAU_DR;
            PAU_DR: n = tms ? EX2_DR : PAU_DR;
            EX2_DR: n = tms ? UPD_DR : SH_DR;
            UPD_DR: n = tms ? SEL_DR : RTI;
            SEL_IR: n = tms ? TLR    : CAP_IR;
            CAP_IR: n = tms ? EX1_IR : SH_IR;
            SH_IR:  n = tms ? EX1_IR : SH_IR;
            EX1_IR: n = tms ? UPD_IR : PAU_IR;
            PAU_IR: n = tms ? EX2_IR : PAU_IR;
            EX2_IR: n = tms ? UPD_IR : SH_IR;
            UPD_IR: n = tms ? SEL_DR : RTI;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Multi-flop synchroniser for the JTAG pads plus tck edge pulses.
// All four inputs share one depth so tms/tdi line up with the tck edge.
module jtag_pin_sync
    import jtag_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trst_ni,
    output logic tms_o,
    output logic tdi_o,
    output logic trst_no,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    logic [STAGES-1:0] tck_q;
    logic [STAGES-1:0] tms_q;
    logic [STAGES-1:0] tdi_q;
    logic [STAGES-1:0] trst_q;
    logic              tck_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            trst_q     <= '1;
            tck_prev_q <= 1'b0;
        end else begin
            tck_q      <= {tck_q[STAGES-2:0], tck_i};
            tms_q      <= {tms_q[STAGES-2:0], tms_i};
            tdi_q      <= {tdi_q[STAGES-2:0], tdi_i};
            trst_q     <= {trst_q[STAGES-2:0], trst_ni};
            tck_prev_q <= tck_q[STAGES-1];
        end
    end

    assign tms_o      = tms_q[STAGES-1];
    assign tdi_o      = tdi_q[STAGES-1];
    assign trst_no    = trst_q[STAGES-1];
    assign tck_rise_o = tck_q[STAGES-1] & ~tck_prev_q;
    assign tck_fall_o = ~tck_q[STAGES-1] & tck_prev_q;

endmodule

// File: rtl/jtag_tap_mux.sv
// Clk-oversampled 1149.1 TAP with IDCODE/BYPASS and one-hot user DR channels.
// Fan-out to the tap_register instances is via user_sel and the strobes.
module jtag_tap_mux
    import jtag_pkg::*;
#(
    parameter int          IR_LEN      = 8,
    parameter logic [31:0] IDCODE_VAL  = 32'h1392001D,
    parameter int          USER_CH     = 8,
    parameter int          USER_BASE   = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trst_n,
    input  logic               tck,
    input  logic               tms,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_en,
    output logic [IR_LEN-1:0]  insn,
    output logic               active,
    output logic [USER_CH-1:0] user_sel,
    output logic               user_tdi,
    input  logic [USER_CH-1:0] user_tdo,
    output logic               user_capture,
    output logic               user_shift,
    output logic               user_update
);

    localparam logic [31:0]       IDC32  = idcode_op(IR_LEN);
    localparam logic [IR_LEN-1:0] IDC_OP = IDC32[IR_LEN-1:0];
    localparam logic [IR_LEN-1:0] IR_CAP = {{(IR_LEN-2){1'b0}}, 2'b01};

    function automatic logic [USER_CH-1:0] dec(logic [IR_LEN-1:0] op);
        logic [USER_CH-1:0] s;
        s = '0;
        for (int k = 0; k < USER_CH; k++) begin
            if (int'(op) == USER_BASE + k) s[k] = 1'b1;
        end
        return s;
    endfunction

    logic tms_s, tdi_s, trst_s, rise, fall;

    jtag_pin_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .tck_i     (tck),
        .tms_i     (tms),
        .tdi_i     (tdi),
        .trst_ni   (trst_n),
        .tms_o     (tms_s),
        .tdi_o     (tdi_s),
        .trst_no   (trst_s),
        .tck_rise_o(rise),
        .tck_fall_o(fall)
    );

    tap_state_e         state_q, state_d;
    logic [IR_LEN-1:0]  ir_q, ir_d;
    logic [IR_LEN-1:0]  insn_q, insn_d;
    logic [31:0]        dr_q, dr_d;
    logic               byp_q, byp_d;
    logic               tdo_q, tdo_d;
    logic               en_q, en_d;
    logic [USER_CH-1:0] sel_q, sel_d;
    logic               cap_q, cap_d;
    logic               sh_q, sh_d;
    logic               upd_q, upd_d;
    logic               is_user;
    logic               dr_out;

    assign is_user = |sel_q;

    always_comb begin
        dr_out = byp_q;
        if (insn_q == IDC_OP) dr_out = dr_q[0];
        else if (is_user)     dr_out = |(user_tdo & sel_q);
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        insn_d  = insn_q;
        dr_d    = dr_q;
        byp_d   = byp_q;
        tdo_d   = tdo_q;
        en_d    = en_q;
        cap_d   = 1'b0;
        sh_d    = 1'b0;
        upd_d   = 1'b0;
        if (rise) begin
            state_d = tap_next(state_q, tms_s);
            unique case (state_q)
                CAP_IR: ir_d = IR_CAP;
                SH_IR:  ir_d = {tdi_s, ir_q[IR_LEN-1:1]};
                CAP_DR: begin
                    dr_d  = IDCODE_VAL;
                    byp_d = 1'b0;
                    cap_d = is_user;
                end
                SH_DR: begin
                    dr_d  = {tdi_s, dr_q[31:1]};
                    byp_d = tdi_s;
                    sh_d  = is_user;
                end
                UPD_DR:  upd_d = is_user;
                default: ;
            endcase
        end
        if (fall) begin
            tdo_d = 1'b0;
            en_d  = 1'b0;
            unique case (state_q)
                SH_IR: begin
                    tdo_d = ir_q[0];
                    en_d  = 1'b1;
                end
                SH_DR: begin
                    tdo_d = dr_out;
                    en_d  = 1'b1;
                end
                UPD_IR:  insn_d = ir_q;
                default: ;
            endcase
        end
        // trst wins over any tms-driven move in the same clk
        if (!trst_s) begin
            state_d = TLR;
            tdo_d   = 1'b0;
            en_d    = 1'b0;
        end
        if (state_d == TLR) insn_d = IDC_OP;
        sel_d = dec(insn_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR;
            ir_q    <= '0;
            insn_q  <= IDC_OP;
            dr_q    <= '0;
            byp_q   <= 1'b0;
            tdo_q   <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= '0;
            cap_q   <= 1'b0;
            sh_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            insn_q  <= insn_d;
            dr_q    <= dr_d;
            byp_q   <= byp_d;
            tdo_q   <= tdo_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            sh_q    <= sh_d;
            upd_q   <= upd_d;
        end
    end

    assign tdo          = tdo_q;
    assign tdo_en       = en_q;
    assign insn         = insn_q;
    assign active       = (state_q != TLR);
    assign user_sel     = sel_q;
    assign user_tdi     = tdi_s;
    assign user_capture = cap_q;
    assign user_shift   = sh_q;
    assign user_update  = upd_q;

endmodule
